// File: rtl/wave_sdram_arbiter.sv
// wave_sdram_arbiter: shares one SDRAM port between the ROM/wave download
// write stream and NV voice read requesters.
// Download writes win over voice reads. Voice reads are granted round-robin.
// Only one SDRAM transaction is in flight at a time.
// Optional feature: define WAVE_ARB_CACHE_EN to add a one-word read cache per voice.
module wave_sdram_arbiter #(
  parameter int NV      = 4,
  parameter int AW      = 20,
  parameter int TIMEOUT = 63
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_dl_active,
  input  logic            i_dl_wr,
  input  logic [24:0]     i_dl_addr,
  input  logic [7:0]      i_dl_data,
  output logic            o_dl_wait,
  input  logic [NV-1:0]   i_v_req,
  input  logic [NV*AW-1:0] i_v_addr,
  output logic [NV-1:0]   o_v_ack,
  output logic [15:0]     o_v_data,
  input  logic            i_sd_ready,
  output logic [24:0]     o_sd_addr,
  output logic            o_sd_rd,
  output logic            o_sd_we,
  output logic [7:0]      o_sd_din,
  input  logic [15:0]     i_sd_dout,
  input  logic            i_sd_done,
  output logic            o_err
);

  localparam int GW = (NV > 1) ? $clog2(NV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_ACK
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic          r_buf_full;
  logic [24:0]   r_buf_addr;
  logic [7:0]    r_buf_data;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] r_grant;
  logic [5:0]    r_cnt;
  logic          r_err;
  logic [15:0]   r_v_data;
  logic [24:0]   r_sd_addr;
  logic [7:0]    r_sd_din;

  logic          w_req_any;
  logic [GW-1:0] w_req_gnt;
  logic [AW-1:0] w_req_addr;
  logic          w_timeout;
  logic          w_hit;
  logic [15:0]   w_hit_data;
  logic          w_sd_rd;
  logic          w_sd_we;
  logic [NV-1:0] w_v_ack;

  // Pick the first requesting voice at or above the round-robin pointer, wrapping modulo NV.
  always_comb begin
    w_req_any = 1'b0;
    w_req_gnt = '0;
    for (int i = 0; i < NV; i++) begin
      if (!w_req_any && i_v_req[(int'(r_rr_ptr) + i) % NV]) begin
        w_req_any = 1'b1;
        w_req_gnt = GW'((int'(r_rr_ptr) + i) % NV);
      end
    end
  end

  assign w_req_addr = i_v_addr[int'(w_req_gnt)*AW +: AW];
  assign w_timeout  = (r_cnt == 6'(TIMEOUT - 1));

`ifdef WAVE_ARB_CACHE_EN
  logic          r_cache_valid [NV];
  logic [AW-1:0] r_cache_tag   [NV];
  logic [15:0]   r_cache_data  [NV];

  assign w_hit      = r_cache_valid[w_req_gnt] && (r_cache_tag[w_req_gnt] == w_req_addr);
  assign w_hit_data = r_cache_data[w_req_gnt];

  // Fill the granted voice's entry on a good read; any download write invalidates everything.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NV; i++) begin
        r_cache_valid[i] <= 1'b0;
        r_cache_tag[i]   <= '0;
        r_cache_data[i]  <= '0;
      end
    end else begin
      if (r_state == S_RD_WAIT && i_sd_done) begin
        r_cache_valid[r_grant] <= 1'b1;
        r_cache_tag[r_grant]   <= r_sd_addr[AW-1:0];
        r_cache_data[r_grant]  <= i_sd_dout;
      end
      if (i_dl_wr) begin
        for (int i = 0; i < NV; i++) begin
          r_cache_valid[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 16'h0000;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the strobes that depend only on the current state.
  always_comb begin
    w_next_state = r_state;
    w_sd_rd      = 1'b0;
    w_sd_we      = 1'b0;
    w_v_ack      = '0;
    case (r_state)
      S_IDLE: begin
        if (i_sd_ready) begin
          if (r_buf_full) begin
            w_next_state = S_WR_ISSUE;
          end else if (!i_dl_active && w_req_any) begin
            w_next_state = w_hit ? S_RD_ACK : S_RD_ISSUE;
          end
        end
      end
      S_WR_ISSUE: begin
        w_sd_we      = 1'b1;
        w_next_state = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (i_sd_done || w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_RD_ISSUE: begin
        w_sd_rd      = 1'b1;
        w_next_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_sd_done || w_timeout) begin
          w_next_state = S_RD_ACK;
        end
      end
      S_RD_ACK: begin
        w_v_ack[r_grant] = 1'b1;
        w_next_state     = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: write buffer, grant/address latch, wait counter, read data and error flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_buf_full <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_v_data   <= '0;
      r_sd_addr  <= '0;
      r_sd_din   <= '0;
    end else begin
      if (i_dl_active && i_dl_wr && !r_buf_full) begin
        r_buf_full <= 1'b1;
        r_buf_addr <= i_dl_addr;
        r_buf_data <= i_dl_data;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_sd_ready) begin
            if (r_buf_full) begin
              r_sd_addr <= r_buf_addr;
              r_sd_din  <= r_buf_data;
            end else if (!i_dl_active && w_req_any) begin
              r_grant   <= w_req_gnt;
              r_sd_addr <= 25'(w_req_addr);
              if (w_hit) begin
                r_v_data <= w_hit_data;
              end
            end
          end
        end
        S_WR_ISSUE, S_RD_ISSUE: begin
          r_cnt <= '0;
        end
        S_WR_WAIT: begin
          if (i_sd_done) begin
            r_buf_full <= 1'b0;
          end else if (w_timeout) begin
            r_buf_full <= 1'b0;
            r_err      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_RD_WAIT: begin
          if (i_sd_done) begin
            r_v_data <= i_sd_dout;
          end else if (w_timeout) begin
            r_v_data <= 16'h0000;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_RD_ACK: begin
          r_rr_ptr <= (r_grant == GW'(NV - 1)) ? '0 : r_grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_dl_wait = r_buf_full;
  assign o_v_ack   = w_v_ack;
  assign o_v_data  = r_v_data;
  assign o_sd_addr = r_sd_addr;
  assign o_sd_rd   = w_sd_rd;
  assign o_sd_we   = w_sd_we;
  assign o_sd_din  = r_sd_din;
  assign o_err     = r_err;

endmodule
